// File: rtl/hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_controller_pkg
// Shared types and constants for the pipeline hazard controller.
//   forward_mux_code : operand forward select for the instruction entering EX
//   hz_state_e       : flush sequencer state
//   CNT_W            : width of the saturating performance counters
// ---------------------------------------------------------------------------
package hazard_controller_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } forward_mux_code;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_e;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_controller_if
// Groups the decode-stage instruction description, the EX redirect and the
// hazard controller's results into one bundle.
//   master : the pipeline side (drives decode info and redirect)
//   slave  : the hazard controller (drives forward selects, stall, flush,
//            performance counters)
// There is no valid/ready handshake here: id_valid_ip qualifies the decode
// slot every cycle, stall_op/flush_op are same-cycle control back to the
// pipeline, and fa/fb selects apply to the instruction entering EX.
// ---------------------------------------------------------------------------
import hazard_controller_pkg::*;

interface hazard_controller_if;
    logic            id_valid_ip;
    logic [4:0]      id_rs1_addr_ip;
    logic [4:0]      id_rs2_addr_ip;
    logic            id_rs1_used_ip;
    logic            id_rs2_used_ip;
    logic [4:0]      id_rd_addr_ip;
    logic            id_reg_write_ip;
    logic            id_is_load_ip;
    logic            ex_redirect_ip;
    forward_mux_code fa_mux_op;
    forward_mux_code fb_mux_op;
    logic            stall_op;
    logic            flush_op;
    logic [CNT_W-1:0] stall_count_op;
    logic [CNT_W-1:0] flush_count_op;

    modport master (
        output id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip,
               id_rs1_used_ip, id_rs2_used_ip, id_rd_addr_ip,
               id_reg_write_ip, id_is_load_ip, ex_redirect_ip,
        input  fa_mux_op, fb_mux_op, stall_op, flush_op,
               stall_count_op, flush_count_op
    );

    modport slave (
        input  id_valid_ip, id_rs1_addr_ip, id_rs2_addr_ip,
               id_rs1_used_ip, id_rs2_used_ip, id_rd_addr_ip,
               id_reg_write_ip, id_is_load_ip, ex_redirect_ip,
        output fa_mux_op, fb_mux_op, stall_op, flush_op,
               stall_count_op, flush_count_op
    );
endinterface

// File: rtl/hazard_controller_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Combinational forward selection for one decode source register.
//   rs_addr_i / rs_used_i : the source and whether it is actually read
//   ex_rd_i / ex_wr_i     : shadow of the instruction now in EX
//   mem_rd_i / mem_wr_i   : shadow of the instruction now in MEM
//   sel_o                 : FWD_EX_MEM beats FWD_MEM_WB beats FWD_NONE
//   ex_match_o            : source hits a nonzero EX destination (used for
//                           load-use detection, independent of ex_wr)
// x0 is hard-wired to zero, so a zero source never matches anything.
// ---------------------------------------------------------------------------
module fwd_select
    import hazard_controller_pkg::*;
(
    input  logic [4:0]      rs_addr_i,
    input  logic            rs_used_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_wr_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_wr_i,
    output forward_mux_code sel_o,
    output logic            ex_match_o
);

    logic live;
    logic mem_match;

    assign live       = rs_used_i && (rs_addr_i != 5'd0);
    assign ex_match_o = live && (rs_addr_i == ex_rd_i);
    assign mem_match  = live && (rs_addr_i == mem_rd_i);

    always_comb begin
        sel_o = FWD_NONE;
        if (ex_match_o && ex_wr_i) begin
            sel_o = FWD_EX_MEM;
        end else if (mem_match && mem_wr_i) begin
            sel_o = FWD_MEM_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Pipeline hazard unit: forwarding selects, load-use stall, redirect flush
// and saturating stall/flush performance counters.
//   clock : rising-edge pipeline clock
//   reset : asynchronous active-high reset
//   hz    : slave side of hazard_controller_if (decode info, ex_redirect_ip,
//           fa/fb_mux_op, stall_op, flush_op, stall/flush counters)
// The block shadows the destination info of the EX and MEM stages; a stall
// or flush loads a bubble into the EX shadow while MEM keeps advancing.
// ---------------------------------------------------------------------------
module hazard_controller
    import hazard_controller_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    hazard_controller_if.slave hz
);

    // Shadow slots
    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_wr_q, ex_wr_d;
    logic       ex_load_q, ex_load_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic       mem_wr_q, mem_wr_d;

    // Registered forward selects
    forward_mux_code fa_q, fa_d;
    forward_mux_code fb_q, fb_d;

    // Flush sequencer and counters
    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    forward_mux_code fwd_a, fwd_b;
    logic            rs1_ex_hit, rs2_ex_hit;
    logic            load_use;
    logic            redirect_accept;
    logic            flush;
    logic            stall;
    logic            bubble;

    fwd_select u_fwd_rs1 (
        .rs_addr_i  (hz.id_rs1_addr_ip),
        .rs_used_i  (hz.id_rs1_used_ip),
        .ex_rd_i    (ex_rd_q),
        .ex_wr_i    (ex_wr_q),
        .mem_rd_i   (mem_rd_q),
        .mem_wr_i   (mem_wr_q),
        .sel_o      (fwd_a),
        .ex_match_o (rs1_ex_hit)
    );

    fwd_select u_fwd_rs2 (
        .rs_addr_i  (hz.id_rs2_addr_ip),
        .rs_used_i  (hz.id_rs2_used_ip),
        .ex_rd_i    (ex_rd_q),
        .ex_wr_i    (ex_wr_q),
        .mem_rd_i   (mem_rd_q),
        .mem_wr_i   (mem_wr_q),
        .sel_o      (fwd_b),
        .ex_match_o (rs2_ex_hit)
    );

    // A load in EX cannot forward its data yet; a dependent decode must wait.
    assign load_use = hz.id_valid_ip && ex_load_q && (rs1_ex_hit || rs2_ex_hit);

    // FSM next state and flush/stall decode. Reset masks both controls so
    // the pipeline sees neither while reset is held.
    always_comb begin
        state_d         = state_q;
        redirect_accept = 1'b0;
        flush           = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (hz.ex_redirect_ip) begin
                    redirect_accept = 1'b1;
                    flush           = 1'b1;
                    state_d         = HZ_FLUSH;
                end
            end
            HZ_FLUSH: begin
                // Redirect is ignored here: the second flush cycle is fixed.
                flush   = 1'b1;
                state_d = HZ_RUN;
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
        if (reset) begin
            redirect_accept = 1'b0;
            flush           = 1'b0;
        end
    end

    // Flush wins over a coincident load-use.
    assign stall  = load_use && !flush && !reset;
    assign bubble = stall || flush;

    always_comb begin
        mem_rd_d    = ex_rd_q;
        mem_wr_d    = ex_wr_q;
        ex_rd_d     = hz.id_rd_addr_ip;
        ex_wr_d     = hz.id_valid_ip && hz.id_reg_write_ip;
        ex_load_d   = hz.id_valid_ip && hz.id_is_load_ip;
        fa_d        = fwd_a;
        fb_d        = fwd_b;
        if (bubble) begin
            ex_rd_d   = 5'd0;
            ex_wr_d   = 1'b0;
            ex_load_d = 1'b0;
            fa_d      = FWD_NONE;
            fb_d      = FWD_NONE;
        end
        stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = redirect_accept ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= HZ_RUN;
            ex_rd_q     <= 5'd0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_wr_q    <= 1'b0;
            fa_q        <= FWD_NONE;
            fb_q        <= FWD_NONE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.fa_mux_op      = fa_q;
    assign hz.fb_mux_op      = fb_q;
    assign hz.stall_op       = stall;
    assign hz.flush_op       = flush;
    assign hz.stall_count_op = stall_cnt_q;
    assign hz.flush_count_op = flush_cnt_q;

endmodule
